// File: rtl/act_output_packer.sv
// Packs LANES activation elements into one word and buffers finished words in a
// first-word-fall-through FIFO with a valid/ready output and a sticky overflow flag.
module act_output_packer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               valid_in,
  input  logic [DATA_WIDTH-1:0]              data_in,
  input  logic                               flush,
  input  logic                               clear_overflow,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH*LANES-1:0]        out_data,
  output logic [LANES-1:0]                   out_strb,
  output logic                               out_last,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               overflow,
  output logic                               busy
);

  localparam int unsigned LaneW  = $clog2(LANES);
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WordW  = DATA_WIDTH * LANES;
  localparam int unsigned EntryW = WordW + LANES + 1;

  logic [LaneW-1:0]  lane_cnt_q, lane_cnt_d;
  logic [WordW-1:0]  asm_data_q, asm_data_d;
  logic [LANES-1:0]  asm_strb_q, asm_strb_d;
  logic [WordW-1:0]  pk_data;
  logic [LANES-1:0]  pk_strb;
  logic              lane_full, push, push_last, pop, full, accept, drop;
  logic [EntryW-1:0] mem_q [FIFO_DEPTH];
  logic [EntryW-1:0] head;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q, level_d;
  logic              overflow_q, overflow_d;

  // Word as it looks with this cycle's element merged in.
  always_comb begin
    pk_data = asm_data_q;
    pk_strb = asm_strb_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (valid_in && (lane_cnt_q == LaneW'(i))) begin
        pk_data[i*DATA_WIDTH +: DATA_WIDTH] = data_in;
        pk_strb[i]                          = 1'b1;
      end
    end
  end

  always_comb begin
    lane_full = valid_in && (lane_cnt_q == LaneW'(LANES - 1));
    push_last = flush && ((lane_cnt_q != '0) || valid_in);
    push      = lane_full || push_last;
    full      = (level_q == LvlW'(FIFO_DEPTH));
    pop       = out_valid && out_ready;
    accept    = push && (!full || pop);
    drop      = push && !accept;

    lane_cnt_d = lane_cnt_q;
    asm_data_d = asm_data_q;
    asm_strb_d = asm_strb_q;
    if (push) begin
      lane_cnt_d = '0;
      asm_data_d = '0;
      asm_strb_d = '0;
    end else if (valid_in) begin
      lane_cnt_d = lane_cnt_q + LaneW'(1);
      asm_data_d = pk_data;
      asm_strb_d = pk_strb;
    end

    level_d = level_q;
    unique case ({accept, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase

    // A drop in the same cycle as a clear keeps the flag set.
    overflow_d = overflow_q;
    if (clear_overflow) overflow_d = 1'b0;
    if (drop)           overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt_q <= '0;
      asm_data_q <= '0;
      asm_strb_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      lane_cnt_q <= lane_cnt_d;
      asm_data_q <= asm_data_d;
      asm_strb_q <= asm_strb_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      if (accept) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= {push_last, pk_strb, pk_data};
  end

  always_comb begin
    head       = mem_q[rd_ptr_q];
    out_valid  = (level_q != '0);
    out_data   = out_valid ? head[WordW-1:0] : '0;
    out_strb   = out_valid ? head[WordW +: LANES] : '0;
    out_last   = out_valid ? head[EntryW-1] : 1'b0;
    fifo_level = level_q;
    overflow   = overflow_q;
    busy       = (lane_cnt_q != '0) || (level_q != '0);
  end

endmodule
